// File: rtl/lift_controller.sv
// Lift controller: latches floor calls, picks the next target, drives state/floors to the travel timer.
// Latency: a call is visible to the FSM one cycle after sampling; all outputs are registered.
// Backpressure: none; a move holds until the timer's reached pulse. LIFT_DOOR_REOPEN_EN enables door reopen from DOOR_CLOSE.
module lift_controller #(
   parameter int NUM_FLOORS        = 8,
   parameter int DOOR_OPEN_CYCLES  = 4,
   parameter int DOOR_CLOSE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] req,
   input  logic                  reached,
   output logic [31:0]           current_state,
   output logic [31:0]           nfloor,
   output logic [31:0]           pfloor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  dir_up
);

   localparam int FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

   // Codes are shared with the travel timer, so they are fixed values.
   typedef enum logic [2:0] {
      DOOR_OPEN  = 3'd1,
      DOOR_CLOSE = 3'd2,
      READY      = 3'd3,
      MOVE_UP    = 3'd4,
      MOVE_DOWN  = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [FW-1:0]         nfloor_q, nfloor_d;
   logic [FW-1:0]         pfloor_q, pfloor_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic                  dir_q, dir_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [NUM_FLOORS-1:0] clr;

   logic                  above_vld, below_vld;
   logic [FW-1:0]         above_idx, below_idx;

   // Nearest pending call above and below the present floor.
   always_comb begin
      above_vld = 1'b0;
      above_idx = '0;
      below_vld = 1'b0;
      below_idx = '0;
      // Descending scan: the last hit is the lowest floor above.
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending_q[i] && (i > int'(pfloor_q))) begin
            above_vld = 1'b1;
            above_idx = FW'(i);
         end
      end
      // Ascending scan: the last hit is the highest floor below.
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending_q[i] && (i < int'(pfloor_q))) begin
            below_vld = 1'b1;
            below_idx = FW'(i);
         end
      end
   end

   // Next-state logic: FSM transitions, target selection and the served-floor clear mask.
   always_comb begin
      state_d  = state_q;
      nfloor_d = nfloor_q;
      pfloor_d = pfloor_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      clr      = '0;
      case (state_q)
         READY: begin
            cnt_d = 8'd0;
            if (pending_q != '0) begin
               if (pending_q[pfloor_q]) begin
                  state_d       = DOOR_OPEN;
                  clr[pfloor_q] = 1'b1;
               end else if (dir_q) begin
                  if (above_vld) begin
                     nfloor_d = above_idx;
                     state_d  = MOVE_UP;
                  end else begin
                     nfloor_d = below_idx;
                     dir_d    = 1'b0;
                     state_d  = MOVE_DOWN;
                  end
               end else begin
                  if (below_vld) begin
                     nfloor_d = below_idx;
                     state_d  = MOVE_DOWN;
                  end else begin
                     nfloor_d = above_idx;
                     dir_d    = 1'b1;
                     state_d  = MOVE_UP;
                  end
               end
            end
         end
         MOVE_UP, MOVE_DOWN: begin
            // Target is frozen for the whole move; intermediate calls wait.
            if (reached) begin
               pfloor_d       = nfloor_q;
               clr[nfloor_q]  = 1'b1;
               state_d        = DOOR_OPEN;
               cnt_d          = 8'd0;
            end
         end
         DOOR_OPEN: begin
            // Calls for this floor while the door is open are already served.
            clr[pfloor_q] = 1'b1;
            if (cnt_q == 8'(DOOR_OPEN_CYCLES - 1)) begin
               state_d = DOOR_CLOSE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DOOR_CLOSE: begin
`ifdef LIFT_DOOR_REOPEN_EN
            if (req[pfloor_q]) begin
               state_d       = DOOR_OPEN;
               cnt_d         = 8'd0;
               clr[pfloor_q] = 1'b1;
            end else
`endif
            if (cnt_q == 8'(DOOR_CLOSE_CYCLES - 1)) begin
               state_d = READY;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = READY;
            cnt_d   = 8'd0;
         end
      endcase
      // Clear wins over a simultaneous new call for the same floor.
      pending_d = (pending_q | req) & ~clr;
   end

   // State register; synchronous reset overrides any move or dwell in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= READY;
         nfloor_q  <= '0;
         pfloor_q  <= '0;
         pending_q <= '0;
         dir_q     <= 1'b1;
         cnt_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         nfloor_q  <= nfloor_d;
         pfloor_q  <= pfloor_d;
         pending_q <= pending_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
      end
   end

   assign current_state = 32'(state_q);
   assign nfloor        = 32'(nfloor_q);
   assign pfloor        = 32'(pfloor_q);
   assign pending       = pending_q;
   assign dir_up        = dir_q;

endmodule

// File: tb/tb_lift_controller.sv
// Directed bench for lift_controller: expected snapshots queued at drive time, checked after each edge.
// Latency: one snapshot compared per clock, sampled 1 time unit after the rising edge.
// Backpressure: none; the timer's reached pulse is driven directly by the stimulus.
module tb_lift_controller;

   logic        clk;
   logic        rst;
   logic [7:0]  req;
   logic        reached;
   logic [31:0] current_state;
   logic [31:0] nfloor;
   logic [31:0] pfloor;
   logic [7:0]  pending;
   logic        dir_up;

   typedef struct packed {
      logic [31:0] st;
      logic [31:0] nf;
      logic [31:0] pf;
      logic [7:0]  pend;
      logic        dir;
   } snap_t;

   snap_t exp_q[$];
   string tag_q[$];
   int    n_vec;
   int    n_err;

   lift_controller #(
      .NUM_FLOORS       (8),
      .DOOR_OPEN_CYCLES (4),
      .DOOR_CLOSE_CYCLES(2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .reached      (reached),
      .current_state(current_state),
      .nfloor       (nfloor),
      .pfloor       (pfloor),
      .pending      (pending),
      .dir_up       (dir_up)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, queue the expected post-edge snapshot, then check it.
   task automatic cyc(input string tag, input logic [7:0] r, input logic rc,
                      input int st, input int nf, input int pf,
                      input logic [7:0] pend, input logic dir);
      snap_t e, g;
      string t;
      req     = r;
      reached = rc;
      e.st = st; e.nf = nf; e.pf = pf; e.pend = pend; e.dir = dir;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g.st = current_state; g.nf = nfloor; g.pf = pfloor; g.pend = pending; g.dir = dir_up;
      n_vec++;
      assert (g === e) else begin
         n_err++;
         $error("FAIL %s: got st=%0d nf=%0d pf=%0d pend=%h dir=%b, want st=%0d nf=%0d pf=%0d pend=%h dir=%b",
                t, g.st, g.nf, g.pf, g.pend, g.dir, e.st, e.nf, e.pf, e.pend, e.dir);
      end
      req     = 8'h00;
      reached = 1'b0;
   endtask

   // Remainder of a door cycle after the arrival edge: 3 more open, 2 close, then READY.
   task automatic door(input string tag, input int nf, input int pf,
                       input logic [7:0] pend, input logic dir);
      cyc({tag, "_open1"}, 8'h00, 1'b0, 1, nf, pf, pend, dir);
      cyc({tag, "_open2"}, 8'h00, 1'b0, 1, nf, pf, pend, dir);
      cyc({tag, "_open3"}, 8'h00, 1'b0, 1, nf, pf, pend, dir);
      cyc({tag, "_close1"}, 8'h00, 1'b0, 2, nf, pf, pend, dir);
      cyc({tag, "_close2"}, 8'h00, 1'b0, 2, nf, pf, pend, dir);
      cyc({tag, "_ready"}, 8'h00, 1'b0, 3, nf, pf, pend, dir);
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst     = 1'b1;
      req     = 8'h00;
      reached = 1'b0;

      // Reset from power-up
      cyc("t1_rst_a", 8'h00, 1'b0, 3, 0, 0, 8'h00, 1'b1);
      cyc("t1_rst_b", 8'h00, 1'b0, 3, 0, 0, 8'h00, 1'b1);
      rst = 1'b0;
      cyc("idle_reached", 8'h00, 1'b1, 3, 0, 0, 8'h00, 1'b1);

      // Up trip 0 -> 5
      cyc("t2_latch",  8'h20, 1'b0, 3, 0, 0, 8'h20, 1'b1);
      cyc("t2_target", 8'h00, 1'b0, 4, 5, 0, 8'h20, 1'b1);
      cyc("t2_hold_a", 8'h00, 1'b0, 4, 5, 0, 8'h20, 1'b1);
      cyc("t2_hold_b", 8'h00, 1'b0, 4, 5, 0, 8'h20, 1'b1);
      cyc("t2_arrive", 8'h00, 1'b1, 1, 5, 5, 8'h00, 1'b1);
      door("t2", 5, 5, 8'h00, 1'b1);

      // Local call at floor 5, then a call for floor 5 during DOOR_CLOSE
      cyc("t6_local_latch", 8'h20, 1'b0, 3, 5, 5, 8'h20, 1'b1);
      cyc("t6_local_open",  8'h00, 1'b0, 1, 5, 5, 8'h00, 1'b1);
      cyc("t6_open_call",   8'h20, 1'b0, 1, 5, 5, 8'h00, 1'b1);
      cyc("t6_open_reach",  8'h00, 1'b1, 1, 5, 5, 8'h00, 1'b1);
      cyc("t6_open_c",      8'h00, 1'b0, 1, 5, 5, 8'h00, 1'b1);
      cyc("t6_close",       8'h00, 1'b0, 2, 5, 5, 8'h00, 1'b1);
`ifdef LIFT_DOOR_REOPEN_EN
      cyc("t6_reopen",      8'h20, 1'b0, 1, 5, 5, 8'h00, 1'b1);
`else
      cyc("t6_call",        8'h20, 1'b0, 2, 5, 5, 8'h20, 1'b1);
      cyc("t6_ready",       8'h00, 1'b0, 3, 5, 5, 8'h20, 1'b1);
      cyc("t6_reopen",      8'h00, 1'b0, 1, 5, 5, 8'h00, 1'b1);
`endif
      door("t6_tail", 5, 5, 8'h00, 1'b1);

      // Start a down move, then reset in the middle of it
      cyc("down_latch",  8'h08, 1'b0, 3, 5, 5, 8'h08, 1'b1);
      cyc("down_target", 8'h00, 1'b0, 5, 3, 5, 8'h08, 1'b0);
      rst = 1'b1;
      cyc("t1_mid_a", 8'h00, 1'b0, 3, 0, 0, 8'h00, 1'b1);
      cyc("t1_mid_b", 8'h10, 1'b1, 3, 0, 0, 8'h00, 1'b1);
      rst = 1'b0;

      // Reach floor 3 heading up, then direction preference with pending 8'h42
      cyc("t3_pre_latch", 8'h08, 1'b0, 3, 0, 0, 8'h08, 1'b1);
      cyc("t3_pre_go",    8'h00, 1'b0, 4, 3, 0, 8'h08, 1'b1);
      cyc("t3_pre_arr",   8'h00, 1'b1, 1, 3, 3, 8'h00, 1'b1);
      door("t3_pre", 3, 3, 8'h00, 1'b1);
      cyc("t3_latch", 8'h42, 1'b0, 3, 3, 3, 8'h42, 1'b1);
      cyc("t3_up",    8'h00, 1'b0, 4, 6, 3, 8'h42, 1'b1);
      cyc("t3_arr6",  8'h00, 1'b1, 1, 6, 6, 8'h02, 1'b1);
      door("t3_at6", 6, 6, 8'h02, 1'b1);
      cyc("t3_down",  8'h00, 1'b0, 5, 1, 6, 8'h02, 1'b0);
      cyc("t3_arr1",  8'h00, 1'b1, 1, 1, 1, 8'h00, 1'b0);
      door("t3_at1", 1, 1, 8'h00, 1'b0);

      // Move to floor 2 (direction flips up), then a local call there
      cyc("t4_pre_latch", 8'h04, 1'b0, 3, 1, 1, 8'h04, 1'b0);
      cyc("t4_pre_go",    8'h00, 1'b0, 4, 2, 1, 8'h04, 1'b1);
      cyc("t4_pre_arr",   8'h00, 1'b1, 1, 2, 2, 8'h00, 1'b1);
      door("t4_pre", 2, 2, 8'h00, 1'b1);
      cyc("t4_latch", 8'h04, 1'b0, 3, 2, 2, 8'h04, 1'b1);
      cyc("t4_open",  8'h00, 1'b0, 1, 2, 2, 8'h00, 1'b1);
      door("t4", 2, 2, 8'h00, 1'b1);

      // Back to floor 0, then 0 -> 6 with an intermediate call for floor 3
      cyc("t5_pre_latch", 8'h01, 1'b0, 3, 2, 2, 8'h01, 1'b1);
      cyc("t5_pre_go",    8'h00, 1'b0, 5, 0, 2, 8'h01, 1'b0);
      cyc("t5_pre_arr",   8'h00, 1'b1, 1, 0, 0, 8'h00, 1'b0);
      door("t5_pre", 0, 0, 8'h00, 1'b0);
      cyc("t5_latch",   8'h40, 1'b0, 3, 0, 0, 8'h40, 1'b0);
      cyc("t5_up",      8'h00, 1'b0, 4, 6, 0, 8'h40, 1'b1);
      cyc("t5_midcall", 8'h08, 1'b0, 4, 6, 0, 8'h48, 1'b1);
      cyc("t5_hold",    8'h00, 1'b0, 4, 6, 0, 8'h48, 1'b1);
      cyc("t5_arr",     8'h00, 1'b1, 1, 6, 6, 8'h08, 1'b1);
      door("t5_at6", 6, 6, 8'h08, 1'b1);
      cyc("t5_down",    8'h00, 1'b0, 5, 3, 6, 8'h08, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
